edge_detector: RTL and testbench



---
 rtl/edge_detector.sv | 181 ++++++++++++++++++
 tb/tb_edge_detector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/edge_detector.sv
// Streaming Sobel edge detector: loads one gray frame in raster order, then emits
// |Gx|+|Gy| (saturated to 8 bits) for every pixel with zero-padded borders.
module edge_detector #(
  parameter int KX_SIZE    = 3,
  parameter int KY_SIZE    = 3,
  parameter int IMG_X_SIZE = 3,
  parameter int IMG_Y_SIZE = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] GrayImage_i,
  output logic       dataAvailable_o,
  output logic       valid_o,
  output logic [7:0] ProcessedImagePixel_o
);

  localparam int N   = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int AW  = (N > 1) ? $clog2(N) : 1;
  localparam int KHX = KX_SIZE / 2;
  localparam int KHY = KY_SIZE / 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     load_idx_q, load_idx_d;
  logic [AW-1:0]     out_row_q, out_row_d;
  logic [AW-1:0]     out_col_q, out_col_d;
  logic              out_done_q, out_done_d;
  logic              dav_q, dav_d;
  logic              valid_q, valid_d;
  logic [7:0]        pix_q, pix_d;
  logic              wr_en_s;

  logic [7:0]        frame_q [N];
  logic [7:0]        tap_s [KY_SIZE][KX_SIZE];
  logic signed [11:0] gx_s, gy_s;
  logic signed [11:0] ax_s, ay_s;
  logic [11:0]       sum_s;
  logic [7:0]        mag_s;

  function automatic logic signed [11:0] ext(input logic [7:0] v);
    return $signed({4'd0, v});
  endfunction

  // Fetch the 3x3 neighbourhood of the current output pixel; out-of-image taps read 0.
  always_comb begin : tap_fetch
    int rr;
    int cc;
    rr = 0;
    cc = 0;
    for (int dy = 0; dy < KY_SIZE; dy++) begin
      for (int dx = 0; dx < KX_SIZE; dx++) begin
        rr = int'(out_row_q) + dy - KHY;
        cc = int'(out_col_q) + dx - KHX;
        if (rr >= 0 && rr < IMG_Y_SIZE && cc >= 0 && cc < IMG_X_SIZE) begin
          tap_s[dy][dx] = frame_q[AW'(rr * IMG_X_SIZE + cc)];
        end else begin
          tap_s[dy][dx] = 8'd0;
        end
      end
    end
  end

  // Sobel gradients, absolute values and saturated magnitude.
  always_comb begin
    gx_s = (ext(tap_s[0][2]) + (ext(tap_s[1][2]) <<< 1) + ext(tap_s[2][2]))
         - (ext(tap_s[0][0]) + (ext(tap_s[1][0]) <<< 1) + ext(tap_s[2][0]));
    gy_s = (ext(tap_s[2][0]) + (ext(tap_s[2][1]) <<< 1) + ext(tap_s[2][2]))
         - (ext(tap_s[0][0]) + (ext(tap_s[0][1]) <<< 1) + ext(tap_s[0][2]));
    ax_s  = gx_s[11] ? -gx_s : gx_s;
    ay_s  = gy_s[11] ? -gy_s : gy_s;
    sum_s = $unsigned(ax_s) + $unsigned(ay_s);
    if (sum_s > 12'd255) begin
      mag_s = 8'd255;
    end else begin
      mag_s = sum_s[7:0];
    end
  end

  // Control FSM: next state, counters and output register inputs.
  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    out_done_d = out_done_q;
    dav_d      = dav_q;
    valid_d    = 1'b0;
    pix_d      = pix_q;
    wr_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dav_d = 1'b0;
        if (start_i) begin
          state_d    = ST_LOAD;
          load_idx_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        wr_en_s = 1'b1;
        if (load_idx_q == AW'(N - 1)) begin
          state_d    = ST_COMPUTE;
          dav_d      = 1'b1;
          load_idx_d = '0;
          out_row_d  = '0;
          out_col_d  = '0;
          out_done_d = 1'b0;
        end else begin
          load_idx_d = load_idx_q + AW'(1);
        end
      end
      ST_COMPUTE: begin
        if (!out_done_q) begin
          valid_d = 1'b1;
          pix_d   = mag_s;
          if (out_col_q == AW'(IMG_X_SIZE - 1)) begin
            out_col_d = '0;
            if (out_row_q == AW'(IMG_Y_SIZE - 1)) begin
              out_row_d  = '0;
              out_done_d = 1'b1;
            end else begin
              out_row_d = out_row_q + AW'(1);
            end
          end else begin
            out_col_d = out_col_q + AW'(1);
          end
        end else begin
          state_d    = ST_IDLE;
          dav_d      = 1'b0;
          out_done_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dav_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      load_idx_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      out_done_q <= 1'b0;
      dav_q      <= 1'b0;
      valid_q    <= 1'b0;
      pix_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      out_done_q <= out_done_d;
      dav_q      <= dav_d;
      valid_q    <= valid_d;
      pix_q      <= pix_d;
    end
  end

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      frame_q[load_idx_q] <= GrayImage_i;
    end
  end

  assign dataAvailable_o       = dav_q;
  assign valid_o               = valid_q;
  assign ProcessedImagePixel_o = pix_q;

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: table of 3x3 frames with hand-computed outputs,
// plus reset-abort and start-during-compute sequences.
module tb_edge_detector;

  typedef logic [8:0][7:0] frame_t;
  typedef struct packed {
    frame_t pix;
    frame_t exp;
    logic   pulse;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] gray = 8'd0;
  logic       dav;
  logic       valid;
  logic [7:0] pix_out;

  int checks = 0;
  int errors = 0;
  vec_t vecs [5];
  frame_t f_a, f_e, f_f, x_a, x_e, x_f;

  edge_detector #(
    .KX_SIZE(3), .KY_SIZE(3), .IMG_X_SIZE(3), .IMG_Y_SIZE(3)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .start_i               (start),
    .GrayImage_i           (gray),
    .dataAvailable_o       (dav),
    .valid_o               (valid),
    .ProcessedImagePixel_o (pix_out)
  );

  always #5 clk = ~clk;

  function automatic frame_t f9(input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5,
                                input int a6, input int a7, input int a8);
    frame_t r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2);
    r[3] = 8'(a3); r[4] = 8'(a4); r[5] = 8'(a5);
    r[6] = 8'(a6); r[7] = 8'(a7); r[8] = 8'(a8);
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " dav"},   {7'd0, dav},   8'd0);
    check({tag, " valid"}, {7'd0, valid}, 8'd0);
  endtask

  task automatic run_frame(input frame_t p, input frame_t e, input logic pulse, input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      gray = p[k];
      check_quiet($sformatf("%s load%0d", tag, k));
      tick();
    end
    check($sformatf("%s dav_rise", tag), {7'd0, dav}, 8'd1);
    check($sformatf("%s valid_before", tag), {7'd0, valid}, 8'd0);
    for (int j = 0; j < 9; j++) begin
      gray  = 8'($urandom);
      start = pulse;
      tick();
      check($sformatf("%s valid%0d", tag, j), {7'd0, valid}, 8'd1);
      check($sformatf("%s dav%0d", tag, j), {7'd0, dav}, 8'd1);
      check($sformatf("%s pix%0d", tag, j), pix_out, e[j]);
    end
    tick();
    start = 1'b0;
    check_quiet($sformatf("%s done", tag));
    check($sformatf("%s hold", tag), pix_out, e[8]);
  endtask

  initial begin
    f_a = f9(10, 20, 30, 40, 50, 60, 70, 80, 90);
    x_a = f9(220, 255, 255, 255, 255, 255, 255, 255, 255);
    f_e = f9(5, 0, 0, 0, 0, 0, 0, 0, 0);
    x_e = f9(0, 10, 0, 10, 10, 0, 0, 0, 0);
    f_f = f9(0, 7, 0, 0, 0, 0, 0, 0, 0);
    x_f = f9(14, 0, 14, 14, 14, 14, 0, 0, 0);

    vecs[0].pix = f9(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0].exp = f9(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0].pulse = 1'b0;
    vecs[1].pix = f9(100, 100, 100, 100, 100, 100, 100, 100, 100);
    vecs[1].exp = f9(255, 255, 255, 255, 0, 255, 255, 255, 255);
    vecs[1].pulse = 1'b1;
    vecs[2].pix = f9(0, 0, 0, 0, 4, 0, 0, 0, 0);
    vecs[2].exp = f9(8, 8, 8, 8, 0, 8, 8, 8, 8);
    vecs[2].pulse = 1'b0;
    vecs[3].pix = f_e;
    vecs[3].exp = x_e;
    vecs[3].pulse = 1'b0;
    vecs[4].pix = f_a;
    vecs[4].exp = x_a;
    vecs[4].pulse = 1'b1;

    // Reset state, then idle without start.
    #2;
    check_quiet("reset");
    check("reset pix", pix_out, 8'd0);
    #10;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_quiet($sformatf("idle%0d", i));
      check($sformatf("idle%0d pix", i), pix_out, 8'd0);
    end

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].pix, vecs[v].exp, vecs[v].pulse, $sformatf("vec%0d", v));
    end

    // Abort mid-LOAD after four pixels; output must clear without a clock edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gray = f_e[k];
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    check_quiet("rst_load");
    check("rst_load pix", pix_out, 8'd0);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet($sformatf("post_rst_load%0d", i));
    end
    run_frame(f_f, x_f, 1'b0, "after_load_rst");

    // Abort mid-COMPUTE.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      gray = f_a[k];
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      tick();
    end
    check("mid_compute valid", {7'd0, valid}, 8'd1);
    check("mid_compute pix", pix_out, x_a[2]);
    #2;
    rst = 1'b0;
    #1;
    check_quiet("rst_compute");
    check("rst_compute pix", pix_out, 8'd0);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet($sformatf("post_rst_compute%0d", i));
    end
    run_frame(f_e, x_e, 1'b0, "after_compute_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
